cal_average_accum: RTL and testbench



---
 rtl/cal_average_accum.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_cal_average_accum.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_average_accum.sv
// cal_average_accum
// Frame-averaging accumulator for the calibrator datapath. The external
// synchronous FIFO (ACC_W wide, NBINS deep) holds one partial sum per bin.
// 2^shift consecutive frames are summed bin by bin, and the floor-shifted
// average is emitted while the last frame streams through. A flush pulse
// aborts the running average and drains whatever the FIFO still holds.
module cal_average_accum #(
    parameter int DIN_W         = 24,
    parameter int ACC_W         = 28,
    parameter int NBINS         = 512,
    parameter int RD_LAT        = 2,
    parameter int AVG_SHIFT_MAX = 4
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [2:0]              avg_shift,
    input  logic                    flush,
    input  logic                    din_valid,
    input  logic signed [DIN_W-1:0] din,
    output logic                    din_ready,
    output logic                    dout_valid,
    output logic signed [DIN_W-1:0] dout,
    output logic                    dout_last,
    output logic                    busy,
    output logic                    err_underflow,
    output logic                    err_overflow,
    output logic                    fifo_we,
    output logic [ACC_W-1:0]        fifo_data,
    output logic                    fifo_re,
    input  logic [ACC_W-1:0]        fifo_q,
    input  logic                    fifo_empty,
    input  logic                    fifo_full
);

    localparam int BIN_W = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int FRM_W = (AVG_SHIFT_MAX > 0) ? AVG_SHIFT_MAX : 1;
    localparam int SH_W  = 3;
    localparam int EC_W  = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_ACCUM = 3'd2,
        ST_LAST  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s, mode_s;
    logic [BIN_W-1:0]   bin_cnt_r, bin_nxt_s;
    logic [FRM_W-1:0]   frm_cnt_r, frm_nxt_s, frm_inc_s, frm_last_s;
    logic [SH_W-1:0]    shift_q_r, shift_clamped_s, shift_eff_s;
    logic [EC_W-1:0]    ecnt_r, ecnt_nxt_s;

    logic period_start_s, din_ready_s, accept_s, bin_wrap_s, flush_start_s;
    logic need_read_s, need_write_s, emit_s;
    logic fifo_re_s, fifo_we_s;
    logic err_underflow_r, err_overflow_r;
    logic err_underflow_nxt_s, err_overflow_nxt_s;

    // Alignment pipeline: carries the accepted sample and its control
    // bits for RD_LAT cycles so it meets the matching fifo_q word.
    logic [RD_LAT-1:0]       pwr_r, pem_r, prd_r, plast_r;
    logic signed [DIN_W-1:0] pdin_r [RD_LAT];
    logic [SH_W-1:0]         psh_r  [RD_LAT];

    logic signed [ACC_W-1:0] q_term_s, din_ext_s, sum_s;
    logic [DIN_W-1:0]        dout_nxt_s;

    logic                    fifo_we_r, dout_valid_r, dout_last_r;
    logic [ACC_W-1:0]        fifo_data_r;
    logic [DIN_W-1:0]        dout_r;

    // Decode the accept, the effective shift and what this bin needs from the FIFO.
    always_comb begin
        period_start_s = (bin_cnt_r == '0) && (frm_cnt_r == '0);
        if (avg_shift > SH_W'(AVG_SHIFT_MAX)) begin
            shift_clamped_s = SH_W'(AVG_SHIFT_MAX);
        end else begin
            shift_clamped_s = avg_shift;
        end
        if (period_start_s) begin
            shift_eff_s = shift_clamped_s;
        end else begin
            shift_eff_s = shift_q_r;
        end
        frm_last_s    = FRM_W'((32'd1 << shift_eff_s) - 32'd1);
        frm_inc_s     = frm_cnt_r + FRM_W'(1);
        bin_wrap_s    = (bin_cnt_r == BIN_W'(NBINS - 1));
        flush_start_s = flush && (state_r != ST_FLUSH);
        din_ready_s   = (state_r != ST_FLUSH) && !flush;
        accept_s      = din_valid && din_ready_s;

        // The accept that leaves IDLE is already the first bin of the period.
        case (state_r)
            ST_IDLE: begin
                if (shift_eff_s == SH_W'(0)) begin
                    mode_s = ST_LAST;
                end else begin
                    mode_s = ST_FIRST;
                end
            end
            ST_FIRST: mode_s = ST_FIRST;
            ST_ACCUM: mode_s = ST_ACCUM;
            ST_LAST:  mode_s = ST_LAST;
            default:  mode_s = ST_IDLE;
        endcase

        need_read_s  = (mode_s == ST_ACCUM) ||
                       ((mode_s == ST_LAST) && (shift_eff_s != SH_W'(0)));
        need_write_s = (mode_s == ST_FIRST) || (mode_s == ST_ACCUM);
        emit_s       = (mode_s == ST_LAST);

        fifo_re_s = (accept_s && need_read_s) ||
                    ((state_r == ST_FLUSH) && !fifo_empty);
        fifo_we_s = fifo_we_r && !flush;
    end

    // Next state, bin/frame counters, flush drain counter and sticky errors.
    always_comb begin
        state_nxt_s         = state_r;
        bin_nxt_s           = bin_cnt_r;
        frm_nxt_s           = frm_cnt_r;
        ecnt_nxt_s          = ecnt_r;
        err_underflow_nxt_s = err_underflow_r;
        err_overflow_nxt_s  = err_overflow_r;

        if (flush_start_s) begin
            state_nxt_s = ST_FLUSH;
            bin_nxt_s   = '0;
            frm_nxt_s   = '0;
            ecnt_nxt_s  = '0;
        end else if (state_r == ST_FLUSH) begin
            if (fifo_empty) begin
                if (ecnt_r == EC_W'(RD_LAT)) begin
                    state_nxt_s = ST_IDLE;
                    ecnt_nxt_s  = '0;
                end else begin
                    ecnt_nxt_s  = ecnt_r + EC_W'(1);
                end
            end else begin
                ecnt_nxt_s = '0;
            end
        end else if (accept_s) begin
            if (bin_wrap_s) begin
                bin_nxt_s = '0;
                case (mode_s)
                    ST_FIRST, ST_ACCUM: begin
                        frm_nxt_s = frm_inc_s;
                        if (frm_inc_s == frm_last_s) begin
                            state_nxt_s = ST_LAST;
                        end else begin
                            state_nxt_s = ST_ACCUM;
                        end
                    end
                    ST_LAST: begin
                        frm_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end
                    default: begin
                        frm_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end else begin
                bin_nxt_s   = bin_cnt_r + BIN_W'(1);
                state_nxt_s = mode_s;
            end
        end else begin
            state_nxt_s = state_r;
        end

        if (flush_start_s) begin
            err_underflow_nxt_s = 1'b0;
            err_overflow_nxt_s  = 1'b0;
        end else begin
            if (accept_s && need_read_s && fifo_empty) begin
                err_underflow_nxt_s = 1'b1;
            end else begin
                err_underflow_nxt_s = err_underflow_r;
            end
            if (fifo_we_s && fifo_full) begin
                err_overflow_nxt_s = 1'b1;
            end else begin
                err_overflow_nxt_s = err_overflow_r;
            end
        end
    end

    // Control state: FSM, counters, latched shift and error flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r         <= ST_IDLE;
            bin_cnt_r       <= '0;
            frm_cnt_r       <= '0;
            shift_q_r       <= '0;
            ecnt_r          <= '0;
            err_underflow_r <= 1'b0;
            err_overflow_r  <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            bin_cnt_r       <= bin_nxt_s;
            frm_cnt_r       <= frm_nxt_s;
            ecnt_r          <= ecnt_nxt_s;
            err_underflow_r <= err_underflow_nxt_s;
            err_overflow_r  <= err_overflow_nxt_s;
            if (accept_s && period_start_s) begin
                shift_q_r <= shift_clamped_s;
            end
        end
    end

    // Delay the accepted sample and its controls to line up with fifo_q;
    // a flush kills every write still in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwr_r   <= '0;
            pem_r   <= '0;
            prd_r   <= '0;
            plast_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pdin_r[i] <= '0;
                psh_r[i]  <= '0;
            end
        end else begin
            pwr_r[0]   <= accept_s && need_write_s && !flush;
            pem_r[0]   <= accept_s && emit_s;
            prd_r[0]   <= accept_s && need_read_s;
            plast_r[0] <= bin_wrap_s;
            if (accept_s) begin
                pdin_r[0] <= din;
                psh_r[0]  <= shift_eff_s;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pwr_r[i]   <= pwr_r[i-1] && !flush;
                pem_r[i]   <= pem_r[i-1];
                prd_r[i]   <= prd_r[i-1];
                plast_r[i] <= plast_r[i-1];
                pdin_r[i]  <= pdin_r[i-1];
                psh_r[i]   <= psh_r[i-1];
            end
        end
    end

    // Add the stored partial sum (if one was read) to the sign-extended sample.
    always_comb begin
        if (prd_r[RD_LAT-1]) begin
            q_term_s = $signed(fifo_q);
        end else begin
            q_term_s = '0;
        end
        din_ext_s  = {{(ACC_W - DIN_W){pdin_r[RD_LAT-1][DIN_W-1]}}, pdin_r[RD_LAT-1]};
        sum_s      = q_term_s + din_ext_s;
        dout_nxt_s = DIN_W'(sum_s >>> psh_r[RD_LAT-1]);
    end

    // Registered result stage driving the FIFO write port and the averaged output.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fifo_we_r    <= 1'b0;
            fifo_data_r  <= '0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            dout_r       <= '0;
        end else begin
            fifo_we_r    <= pwr_r[RD_LAT-1] && !flush;
            dout_valid_r <= pem_r[RD_LAT-1];
            dout_last_r  <= pem_r[RD_LAT-1] && plast_r[RD_LAT-1];
            if (pwr_r[RD_LAT-1] && !flush) begin
                fifo_data_r <= sum_s;
            end
            if (pem_r[RD_LAT-1]) begin
                dout_r <= dout_nxt_s;
            end
        end
    end

    assign din_ready     = din_ready_s;
    assign busy          = (state_r != ST_IDLE);
    assign err_underflow = err_underflow_r;
    assign err_overflow  = err_overflow_r;
    assign fifo_re       = fifo_re_s;
    assign fifo_we       = fifo_we_s;
    assign fifo_data     = fifo_data_r;
    assign dout_valid    = dout_valid_r;
    assign dout_last     = dout_last_r;
    assign dout          = dout_r;

endmodule

// File: tb/tb_cal_average_accum.sv
// Bench for cal_average_accum: behavioural FIFO plus a per-bin averaging
// model built from frame loops and plain integer arithmetic.
module tb_cal_average_accum;

    localparam int DIN_W  = 24;
    localparam int ACC_W  = 28;
    localparam int NBINS  = 512;
    localparam int RD_LAT = 2;
    localparam int SMAX   = 4;

    logic                    CLK = 1'b0;
    logic                    RESET_N = 1'b0;
    logic [2:0]              avg_shift;
    logic                    flush;
    logic                    din_valid;
    logic signed [DIN_W-1:0] din;
    logic                    din_ready;
    logic                    dout_valid;
    logic signed [DIN_W-1:0] dout;
    logic                    dout_last;
    logic                    busy;
    logic                    err_underflow;
    logic                    err_overflow;
    logic                    fifo_we;
    logic [ACC_W-1:0]        fifo_data;
    logic                    fifo_re;
    logic [ACC_W-1:0]        fifo_q;
    logic                    fifo_empty;
    logic                    fifo_full;

    always #5 CLK = ~CLK;

    cal_average_accum dut (
        .CLK(CLK), .RESET_N(RESET_N), .avg_shift(avg_shift), .flush(flush),
        .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout(dout), .dout_last(dout_last),
        .busy(busy), .err_underflow(err_underflow), .err_overflow(err_overflow),
        .fifo_we(fifo_we), .fifo_data(fifo_data), .fifo_re(fifo_re),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural FIFO (RD_LAT read latency) ----------------
    logic [ACC_W-1:0] fq[$];
    int               fcount = 0;
    logic [ACC_W-1:0] rp0 = '0;
    logic [ACC_W-1:0] rp1 = '0;
    logic             fifo_clr;
    int               fsz;
    logic [ACC_W-1:0] popped;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fq.delete();
            fcount <= 0;
            rp0    <= '0;
            rp1    <= '0;
        end else begin
            popped = '0;
            fsz    = fq.size();
            if (fifo_clr) begin
                fq.delete();
            end else begin
                if (fifo_re && fsz > 0) popped = fq.pop_front();
                if (fifo_we && fsz < NBINS) fq.push_back(fifo_data);
            end
            rp0    <= popped;
            rp1    <= rp0;
            fcount <= fq.size();
        end
    end

    assign fifo_q     = rp1;
    assign fifo_empty = (fcount == 0);
    assign fifo_full  = (fcount == NBINS);

    // ---------------- output scoreboard ----------------
    typedef struct { longint d; bit l; } exp_t;
    exp_t   exp_q[$];
    exp_t   me;
    int     emit_idx = 0;
    longint cap_first = 0;
    longint cap_last  = 0;
    int     we_seen = 0;
    int     re_seen = 0;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            emit_idx = 0;
        end else begin
            if (fifo_we) we_seen++;
            if (fifo_re) re_seen++;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dout_unexpected: got dout=%0d, no output expected", dout);
                end else begin
                    me = exp_q.pop_front();
                    check("dout", dout, me.d);
                    check("dout_last", dout_last, longint'(me.l));
                end
                if (emit_idx == 0) cap_first = dout;
                if (dout_last) begin
                    cap_last = dout;
                    emit_idx = 0;
                end else begin
                    emit_idx++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input longint v, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            din_valid = 1'b0;
            cyc();
        end
        din       = v[DIN_W-1:0];
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
    endtask

    // kind 0: din = bin index; kind 1: v0 in frame 0, v1 afterwards; kind 2: random
    task automatic run_period(input int in_shift, input int kind, input longint v0,
                              input longint v1, input bit gaps);
        longint                  acc [NBINS];
        logic signed [DIN_W-1:0] rv;
        longint                  v;
        exp_t                    e;
        int s  = (in_shift > SMAX) ? SMAX : in_shift;
        int nf = 1 << s;
        avg_shift = 3'(in_shift);
        for (int f = 0; f < nf; f++) begin
            for (int b = 0; b < NBINS; b++) begin
                case (kind)
                    0:       v = b;
                    1:       v = (f == 0) ? v0 : v1;
                    default: begin rv = DIN_W'($urandom); v = rv; end
                endcase
                acc[b] = ((f == 0) ? 64'sd0 : acc[b]) + v;
                if (f == nf - 1) begin
                    e.d = acc[b] >>> s;
                    e.l = (b == NBINS - 1);
                    exp_q.push_back(e);
                end
                send(v, gaps);
                if (f == 0 && b == 0) avg_shift = 3'($urandom_range(0, 7));
            end
        end
        repeat (RD_LAT + 3) cyc();
        check("period_drained", exp_q.size(), 0);
        check("busy_after", busy, 0);
        check("fifo_empty_after", fcount, 0);
        check("err_underflow_after", err_underflow, 0);
        check("err_overflow_after", err_overflow, 0);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 4000) begin
            cyc();
            k++;
        end
        check(name, busy, 0);
    endtask

    typedef struct {
        int     shift;
        int     kind;
        longint v0;
        longint v1;
        bit     gaps;
        longint exp_first;
        longint exp_last;
    } vec_t;

    vec_t tbl[6];
    int   we0, re0;

    initial begin
        tbl[0] = '{0, 0, 0,        0,       1'b0, 0,        511};
        tbl[1] = '{2, 1, 100,      100,     1'b0, 100,      100};
        tbl[2] = '{1, 1, -3,       0,       1'b0, -2,       -2};
        tbl[3] = '{4, 1, 'h7FFFFF, 'h7FFFFF, 1'b0, 'h7FFFFF, 'h7FFFFF};
        tbl[4] = '{4, 1, 'h7FFFFF, 'h7FFFFF, 1'b1, 'h7FFFFF, 'h7FFFFF};
        tbl[5] = '{7, 1, -8388608, 5,       1'b0, -524284,  -524284};

        avg_shift = 3'd0;
        flush     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        fifo_clr  = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_din_ready", din_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_last", dout_last, 0);
        check("rst_fifo_we", fifo_we, 0);
        check("rst_fifo_re", fifo_re, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_err_underflow", err_underflow, 0);
        check("rst_err_overflow", err_overflow, 0);
        RESET_N = 1'b1;
        cyc();

        // table-driven averaging periods
        for (int i = 0; i < 6; i++) begin
            we0 = we_seen;
            re0 = re_seen;
            run_period(tbl[i].shift, tbl[i].kind, tbl[i].v0, tbl[i].v1, tbl[i].gaps);
            check("tbl_bin0", cap_first, tbl[i].exp_first);
            check("tbl_bin511", cap_last, tbl[i].exp_last);
            if (tbl[i].shift == 0) begin
                check("shift0_no_writes", we_seen - we0, 0);
                check("shift0_no_reads", re_seen - re0, 0);
            end
        end

        // randomized periods against the model
        repeat (2) run_period($urandom_range(0, 3), 2, 0, 0, 1'b1);

        // flush at bin 200 of frame 1
        avg_shift = 3'd2;
        for (int b = 0; b < NBINS; b++) send(b * 3 - 700, 1'b0);
        for (int b = 0; b <= 200; b++) send(b + 11, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_din_ready", din_ready, 0);
        check("flush_we_suppressed", fifo_we, 0);
        cyc();
        flush = 1'b0;
        check("flush_busy", busy, 1);
        wait_idle("flush_exit");
        check("flush_fifo_drained", fcount, 0);
        check("flush_din_ready_back", din_ready, 1);
        check("flush_no_output", exp_q.size(), 0);
        run_period(2, 2, 0, 0, 1'b0);

        // stale FIFO contents forced away -> underflow in ACCUM
        avg_shift = 3'd2;
        for (int b = 0; b < NBINS; b++) send(b, 1'b0);
        repeat (RD_LAT + 2) cyc();
        check("first_frame_full", fcount, NBINS);
        fifo_clr = 1'b1;
        cyc();
        fifo_clr = 1'b0;
        check("uf_before", err_underflow, 0);
        send(5, 1'b0);
        check("uf_set", err_underflow, 1);
        for (int b = 1; b <= 20; b++) send(b, 1'b0);
        repeat (4) cyc();
        check("uf_sticky", err_underflow, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("uf_cleared_by_flush", err_underflow, 0);
        wait_idle("uf_flush_exit");
        check("uf_fifo_drained", fcount, 0);

        // asynchronous reset in mid-frame with outputs active
        avg_shift = 3'd0;
        for (int b = 0; b < 100; b++) begin
            me.d = b + 1000;
            me.l = 1'b0;
            exp_q.push_back(me);
            send(b + 1000, 1'b0);
        end
        check("pre_reset_dout_valid", dout_valid, 1);
        din       = 24'd77;
        din_valid = 1'b1;
        #2;
        RESET_N = 1'b0;
        #1;
        exp_q.delete();
        check("arst_dout_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_dout_last", dout_last, 0);
        check("arst_busy", busy, 0);
        check("arst_din_ready", din_ready, 1);
        check("arst_fifo_we", fifo_we, 0);
        check("arst_fifo_re", fifo_re, 0);
        check("arst_fifo_data", fifo_data, 0);
        check("arst_err_underflow", err_underflow, 0);
        din_valid = 1'b0;
        cyc();
        RESET_N = 1'b1;
        cyc();
        run_period(1, 2, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
